// File: rtl/ball_pkg.sv
// Shared definitions for the ball movement controller: USB keycodes, direction
// and state encodings, the speed-to-period table and the motion step decode.
package ball_pkg;

  localparam logic [7:0] KEY_W   = 8'h1A;
  localparam logic [7:0] KEY_S   = 8'h16;
  localparam logic [7:0] KEY_A   = 8'h04;
  localparam logic [7:0] KEY_D   = 8'h07;
  localparam logic [7:0] KEY_ESC = 8'h29;

  localparam logic [9:0] X_MIN = 10'd0;
  localparam logic [9:0] Y_MIN = 10'd0;

  localparam logic [9:0] MOTION_POS = 10'h001;
  localparam logic [9:0] MOTION_NEG = 10'h3FF;

  localparam int CNT_W = 3;
  localparam logic [1:0] SPEED_PAUSE = 2'b11;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WAIT  = 2'b01,
    S_EVAL  = 2'b10,
    S_ISSUE = 2'b11
  } state_e;

  typedef struct packed {
    logic valid;
    dir_e dir;
  } key_dec_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } motion_t;

  // Frames per move; the paused setting loads 0 and the FSM holds while paused.
  function automatic logic [CNT_W-1:0] speed_period(input logic [1:0] speed);
    case (speed)
      2'b00:   return CNT_W'(4);
      2'b01:   return CNT_W'(2);
      2'b10:   return CNT_W'(1);
      default: return CNT_W'(0);
    endcase
  endfunction

  function automatic key_dec_t decode_key(input logic [7:0] code);
    key_dec_t d;
    d.valid = 1'b1;
    d.dir   = DIR_UP;
    case (code)
      KEY_W:   d.dir = DIR_UP;
      KEY_S:   d.dir = DIR_DOWN;
      KEY_A:   d.dir = DIR_LEFT;
      KEY_D:   d.dir = DIR_RIGHT;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // Up<->down and left<->right differ only in the low bit.
  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

  function automatic motion_t dir_motion(input dir_e d);
    motion_t m;
    m.x = '0;
    m.y = '0;
    case (d)
      DIR_UP:    m.y = MOTION_NEG;
      DIR_DOWN:  m.y = MOTION_POS;
      DIR_LEFT:  m.x = MOTION_NEG;
      DIR_RIGHT: m.x = MOTION_POS;
      default:   m.x = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/key_dir_arb.sv
// Turns the four keyboard report slots into a direction request: keeps the
// held set from the previous accepted tick and arbitrates new presses by slot.
module key_dir_arb
  import ball_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       sample,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  dir_e       cur_dir,
  output dir_e       next_dir,
  output logic       valid,
  output logic       stop,
  output logic       any_held
);

  logic [7:0] codes [4];
  key_dec_t   dec   [4];
  logic [3:0] held_q;
  logic [3:0] held_now;
  logic       new_found;
  dir_e       new_dir;
  logic       held_found;
  dir_e       first_dir;

  assign codes = '{keycode0, keycode1, keycode2, keycode3};

  for (genvar i = 0; i < 4; i++) begin : g_dec
    assign dec[i] = decode_key(codes[i]);
  end

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    held_now   = '0;
    stop       = 1'b0;
    new_found  = 1'b0;
    new_dir    = DIR_UP;
    held_found = 1'b0;
    first_dir  = DIR_UP;
    for (int i = 0; i < 4; i++) begin
      if (codes[i] == KEY_ESC) stop = 1'b1;
      if (dec[i].valid) begin
        held_now[dec[i].dir] = 1'b1;
        if (!held_found) begin
          held_found = 1'b1;
          first_dir  = dec[i].dir;
        end
        if (!new_found && !held_q[dec[i].dir]) begin
          new_found = 1'b1;
          new_dir   = dec[i].dir;
        end
      end
    end
  end

  // A change is requested on a fresh press, or when the current key was let go.
  assign any_held = held_found;
  assign valid    = new_found || (held_found && !held_now[cur_dir]);
  assign next_dir = new_found ? new_dir : first_dir;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      held_q <= '0;
    end else if (sample) begin
      held_q <= held_now;
    end
  end

endmodule

// File: rtl/ball_move_ctrl.sv
// Frame-paced movement controller: picks a direction from the keyboard, waits
// the speed period in frames, bounces at the screen edges and issues one step.
module ball_move_ctrl
  import ball_pkg::*;
#(
  parameter int Y_MAX = 479,
  parameter int X_MAX = 639
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic [1:0] speed,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic [9:0] MotionX,
  output logic [9:0] MotionY,
  output logic       move_en,
  output logic [1:0] dir,
  output logic       active
);

  localparam logic [10:0] X_LIM = 11'(X_MAX);
  localparam logic [10:0] Y_LIM = 11'(Y_MAX);

  state_e           state;
  dir_e             dir_q;
  logic [CNT_W-1:0] cnt;
  logic             move_q;

  logic    sample;
  dir_e    arb_dir;
  logic    arb_valid;
  logic    arb_stop;
  logic    arb_any;
  dir_e    tick_dir;
  logic    hit;
  dir_e    eval_dir;
  motion_t eval_mot;
  logic [10:0] sum_x;
  logic [10:0] sum_y;

  // Ticks landing in EVAL or ISSUE are dropped entirely, including key sampling.
  assign sample = frame_tick && (state == S_IDLE || state == S_WAIT);

  key_dir_arb u_arb (
    .Clk      (Clk),
    .Reset    (Reset),
    .sample   (sample),
    .keycode0 (keycode0),
    .keycode1 (keycode1),
    .keycode2 (keycode2),
    .keycode3 (keycode3),
    .cur_dir  (dir_q),
    .next_dir (arb_dir),
    .valid    (arb_valid),
    .stop     (arb_stop),
    .any_held (arb_any)
  );

  assign tick_dir = arb_valid ? arb_dir : dir_q;

  assign sum_x = {1'b0, BallX} + {1'b0, BallS};
  assign sum_y = {1'b0, BallY} + {1'b0, BallS};

  always_comb begin
    hit = 1'b0;
    case (dir_q)
      DIR_UP:    hit = ({1'b0, BallY} <= {1'b0, BallS} + {1'b0, Y_MIN});
      DIR_DOWN:  hit = (sum_y >= Y_LIM);
      DIR_LEFT:  hit = ({1'b0, BallX} <= {1'b0, BallS} + {1'b0, X_MIN});
      DIR_RIGHT: hit = (sum_x >= X_LIM);
      default:   hit = 1'b0;
    endcase
  end

  assign eval_dir = hit ? reverse_dir(dir_q) : dir_q;
  assign eval_mot = dir_motion(eval_dir);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      dir_q   <= DIR_UP;
      cnt     <= '0;
      move_q  <= 1'b0;
      MotionX <= '0;
      MotionY <= '0;
    end else begin
      move_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_tick && !arb_stop && arb_any) begin
            dir_q <= tick_dir;
            cnt   <= speed_period(speed);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (frame_tick) begin
            if (arb_stop) begin
              state   <= S_IDLE;
              MotionX <= '0;
              MotionY <= '0;
            end else begin
              dir_q <= tick_dir;
              if (speed != SPEED_PAUSE) begin
                if (cnt <= CNT_W'(1)) begin
                  cnt   <= '0;
                  state <= S_EVAL;
                end else begin
                  cnt <= cnt - 1'b1;
                end
              end
            end
          end
        end
        S_EVAL: begin
          dir_q   <= eval_dir;
          MotionX <= eval_mot.x;
          MotionY <= eval_mot.y;
          move_q  <= 1'b1;
          state   <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt   <= speed_period(speed);
          state <= S_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset asserted during ISSUE also cancels the pulse already on the output.
  assign move_en = move_q && !Reset;
  assign dir     = dir_q;
  assign active  = (state != S_IDLE);

endmodule

// File: tb/tb_ball_move_ctrl.sv
// Directed bench for ball_move_ctrl: expected move pulses go into a scoreboard
// when a tick is driven and are popped by a monitor when move_en fires.
module tb_ball_move_ctrl;
  import ball_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] keycode0, keycode1, keycode2, keycode3;
  logic [1:0] speed;
  logic [9:0] BallX, BallY, BallS;
  logic [9:0] MotionX, MotionY;
  logic       move_en;
  logic [1:0] dir;
  logic       active;

  typedef struct {
    int         cyc;
    logic [9:0] mx;
    logic [9:0] my;
    logic [1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  ball_move_ctrl #(.Y_MAX(479), .X_MAX(639)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .keycode0   (keycode0),
    .keycode1   (keycode1),
    .keycode2   (keycode2),
    .keycode3   (keycode3),
    .speed      (speed),
    .BallX      (BallX),
    .BallY      (BallY),
    .BallS      (BallS),
    .MotionX    (MotionX),
    .MotionY    (MotionY),
    .move_en    (move_en),
    .dir        (dir),
    .active     (active)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest expectation, including its cycle.
  always @(negedge Clk) begin
    exp_t e;
    if (move_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_move_en", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("move_cycle", 32'(cyc), 32'(e.cyc));
        check("move_MotionX", 32'(MotionX), 32'(e.mx));
        check("move_MotionY", 32'(MotionY), 32'(e.my));
        check("move_dir", 32'(dir), 32'(e.d));
      end
    end
  end

  // One frame of 10 cycles; optionally expects a move 2 cycles after the tick.
  task automatic tick(input bit mv, input logic [9:0] mx, input logic [9:0] my,
                      input logic [1:0] d, input logic [1:0] dir_after);
    @(negedge Clk);
    frame_tick = 1'b1;
    if (mv) sb.push_back('{cyc + 2, mx, my, d});
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (8) @(negedge Clk);
    check("pending_moves", 32'(sb.size()), 32'(0));
    sb.delete();
    check("dir_after_tick", 32'(dir), 32'(dir_after));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    frame_tick = 1'b0;
    keycode0 = 8'h00; keycode1 = 8'h00; keycode2 = 8'h00; keycode3 = 8'h00;
    speed = 2'b10;
    BallX = 10'd320; BallY = 10'd240; BallS = 10'd4;
    repeat (2) @(negedge Clk);

    // Reset wins over a tick with a key held
    keycode0 = KEY_D;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    check("reset_MotionX", 32'(MotionX), 32'(0));
    check("reset_MotionY", 32'(MotionY), 32'(0));
    check("reset_move_en", 32'(move_en), 32'(0));
    check("reset_dir", 32'(dir), 32'(0));
    check("reset_active", 32'(active), 32'(0));
    Reset = 1'b0;

    // Speed 10: entry tick, then a step on every tick
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    check("a_active", 32'(active), 32'(1));
    for (int i = 0; i < 4; i++) begin
      tick(1, 10'h001, 10'h000, 2'b11, 2'b11);
      check("a_MotionX", 32'(MotionX), 32'(10'h001));
      check("a_MotionY", 32'(MotionY), 32'(0));
    end

    // Speed 00 every 4th tick; switch to 01 mid-count
    speed = 2'b00;
    tick(1, 10'h001, 10'h000, 2'b11, 2'b11);
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    check("b_hold_MotionX", 32'(MotionX), 32'(10'h001));
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    tick(1, 10'h001, 10'h000, 2'b11, 2'b11);
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    speed = 2'b01;
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    tick(1, 10'h001, 10'h000, 2'b11, 2'b11);
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    tick(1, 10'h001, 10'h000, 2'b11, 2'b11);

    // Direction arbitration: W, add D in slot 2, release D, release all
    speed = 2'b10;
    keycode0 = KEY_W;
    tick(0, 10'h000, 10'h000, 2'b00, 2'b00);
    tick(1, 10'h000, 10'h3FF, 2'b00, 2'b00);
    keycode2 = KEY_D;
    tick(1, 10'h001, 10'h000, 2'b11, 2'b11);
    keycode2 = 8'h00;
    tick(1, 10'h000, 10'h3FF, 2'b00, 2'b00);
    keycode0 = 8'h00;
    tick(1, 10'h000, 10'h3FF, 2'b00, 2'b00);

    // Bounces: down at BallY+BallS = Y_MAX, left at BallX = BallS
    keycode0 = KEY_S;
    BallY = 10'd475;
    tick(1, 10'h000, 10'h3FF, 2'b00, 2'b00);
    keycode0 = KEY_A;
    BallY = 10'd240;
    BallX = 10'd4;
    tick(1, 10'h001, 10'h000, 2'b11, 2'b11);
    check("d_MotionY", 32'(MotionY), 32'(0));

    // Esc in slot 3 beats D in slot 0
    BallX = 10'd320;
    keycode0 = KEY_D;
    keycode3 = KEY_ESC;
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    check("e_active", 32'(active), 32'(0));
    check("e_MotionX", 32'(MotionX), 32'(0));
    check("e_MotionY", 32'(MotionY), 32'(0));
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    check("e_still_idle", 32'(active), 32'(0));
    keycode3 = 8'h00;
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    check("e_restart_active", 32'(active), 32'(1));
    tick(1, 10'h001, 10'h000, 2'b11, 2'b11);

    // Reset during EVAL cancels the pending step
    @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    check("f_move_en", 32'(move_en), 32'(0));
    check("f_MotionX", 32'(MotionX), 32'(0));
    check("f_MotionY", 32'(MotionY), 32'(0));
    check("f_dir", 32'(dir), 32'(0));
    check("f_active", 32'(active), 32'(0));
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    // A tick arriving during ISSUE is neither sampled nor counted
    tick(0, 10'h000, 10'h000, 2'b11, 2'b11);
    @(negedge Clk);
    frame_tick = 1'b1;
    sb.push_back('{cyc + 2, 10'h001, 10'h000, 2'b11});
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
    check("g_issue_move_en", 32'(move_en), 32'(1));
    keycode0 = KEY_W;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    keycode0 = KEY_D;
    repeat (8) @(negedge Clk);
    check("g_pending_moves", 32'(sb.size()), 32'(0));
    sb.delete();
    check("g_dir_unchanged", 32'(dir), 32'(2'b11));
    tick(1, 10'h001, 10'h000, 2'b11, 2'b11);
    keycode0 = KEY_W;
    tick(1, 10'h000, 10'h3FF, 2'b00, 2'b00);

    repeat (4) @(negedge Clk);
    check("final_queue_empty", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ball_move_ctrl.md
BALL_MOVE_CTRL -- requirements
Module: ball_move_ctrl

Interface
REQ-001 SHALL have parameter Y_MAX, default 479, meaning bottom bound in pixels.
REQ-002 SHALL have parameter X_MAX, default 639, meaning right bound in pixels.
REQ-003 SHALL have the ports listed in REQ-004 to REQ-014, clock and reset first.
REQ-004 Clk  input  1  system clock; one clock; reset is synchronous and active-high.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle vsync strobe, at least 4 Clk cycles apart.
REQ-007 keycode0..keycode3  input  8 each  USB boot-report key slots, 0x00 = empty.
REQ-008 speed  input  2  move period: 00 = 4 frames, 01 = 2, 10 = 1, 11 = paused.
REQ-009 BallX, BallY  input  10 each  current sprite position, fed back from the motion datapath.
REQ-010 BallS  input  10  sprite half-size.
REQ-011 MotionX, MotionY  output  10 each  two's-complement step; +1 = 10'h001, -1 = 10'h3FF.
REQ-012 move_en  output  1  one-cycle pulse; datapath adds Motion to position on this cycle.
REQ-013 dir  output  2  current direction: 00 = up, 01 = down, 10 = left, 11 = right.
REQ-014 active  output  1  high when state is not IDLE.

Function
REQ-015 SHALL map keycodes as follows: 0x1A = up (W), 0x16 = down (S), 0x04 = left (A), 0x07 = right (D), 0x29 = stop (Esc); all other codes are ignored.
REQ-016 SHALL sample all slots only on frame_tick cycles and register the per-direction held set.
REQ-017 A newly pressed direction (held now, not held at previous tick) SHALL become dir; among simultaneous new presses, lowest slot index wins.
REQ-018 If the dir key is released while other direction keys remain held, dir SHALL move to the lowest-index slot still holding a direction key.
REQ-019 With no direction key held, dir SHALL be retained (momentum).
REQ-020 Duplicate codes across slots SHALL count as one key.
REQ-021 FSM states: IDLE, WAIT, EVAL, ISSUE.
REQ-022 IDLE -> WAIT on the first frame_tick with any direction key held; the frame counter loads the speed period.
REQ-023 WAIT: each frame_tick decrements the counter; on the tick where the counter reaches 0 -> EVAL; speed = 11 holds the counter and state.
REQ-024 EVAL (1 cycle) SHALL perform the bounce check on the registered dir and reverse dir when the bound is hit: up if BallY <= BallS; down if BallY+BallS >= Y_MAX; left if BallX <= BallS; right if BallX+BallS >= X_MAX.
REQ-025 Bounce sums SHALL be computed at 11 bits, with no wrap.
REQ-026 ISSUE (1 cycle) SHALL drive move_en = 1 with MotionX/MotionY for the post-EVAL dir, reload the counter from the current speed, and go to WAIT.
REQ-027 move_en SHALL rise exactly 2 cycles after the expiring frame_tick.
REQ-028 The non-moving axis Motion SHALL be 0.
REQ-029 Motion values SHALL hold between pulses.
REQ-030 frame_tick arriving in EVAL or ISSUE SHALL be dropped, with no sampling and no decrement.
REQ-031 A speed change SHALL take effect only at the next counter reload.
REQ-032 Esc held at a tick SHALL send any state to IDLE, zero MotionX/MotionY, and suppress move_en.
REQ-033 Esc SHALL take priority over direction keys in the same report.

Reset
REQ-034 On Reset, the next clock edge SHALL set state IDLE, MotionX = MotionY = 0, move_en = 0, dir = 00, active = 0, counter = 0, and the held set cleared.
REQ-035 Reset mid-EVAL or mid-ISSUE SHALL abort with no move_en pulse.
REQ-036 Reset SHALL override frame_tick in the same cycle.

Structure
REQ-037 Package ball_pkg SHALL hold: the keycode constants, the dir enum, the state enum, the speed-to-period table, and the X_MIN/Y_MIN = 0 constants.
REQ-038 One sub-module, key_dir_arb, SHALL own the held-set register, new-press detection and the slot-priority arbitration.
REQ-039 key_dir_arb SHALL output a next_dir plus a valid flag and a stop flag.

Verification
REQ-040 The bench SHALL cover: Reset, then keycode0 = 0x07, speed = 10, ticks every 10 cycles at BallX = 320, BallS = 4 -> each tick gives move_en 2 cycles later with MotionX = 10'h001, MotionY = 0, dir = 11.
REQ-041 The bench SHALL cover: speed = 00, hold D -> move_en on every 4th tick only; switching speed to 01 mid-count keeps 4 until the next reload, then 2.
REQ-042 The bench SHALL cover: hold W, then add 0x07 in slot 2 at tick N -> dir = 11 from tick N; release D -> dir returns to 00; release all -> dir stays 00.
REQ-043 The bench SHALL cover: dir down, BallY = 475, BallS = 4 at EVAL -> dir = 00, MotionY = 10'h3FF; also left at BallX = 4 -> MotionX = 10'h001.
REQ-044 The bench SHALL cover: Esc in slot 3 while D is held in slot 0 -> IDLE, Motion = 0, no further move_en until a direction key is pressed at a later tick.
REQ-045 The bench SHALL cover: Reset asserted the cycle after the expiring tick -> no move_en, all outputs zero next cycle; a tick injected during ISSUE is ignored.
